timer_timebase_gen: RTL
=======================

// Module: timer_timebase_gen
// PURPOSE
//   Time-base generator directly upstream of the PLC timer bank. Divides clk into one-cycle
//   tick pulses at four decade resolutions: base, x10, x100 and x1000.
//   A selected tick drives each timer's count-enable qualification, so timer ACC advances
//   once per time-base unit instead of once per clk. The divisor is loadable at run time
//   by the processor.
// PARAMETERS
//   DIV_W        16    width of divisor register and prescaler counter
//   DEFAULT_DIV  1000  divisor value loaded at reset (clk cycles per base tick)
// PORTS
//   clk        in   1      system clock; all state changes on posedge
//   reset      in   1      asynchronous, active-high; clears all state
//   run        in   1      1 = prescaler advances; 0 = all counters hold, no ticks
//   sync_clr   in   1      synchronous restart of prescaler and decade counters
//   div_load   in   1      one-cycle strobe: capture div_value into divisor register
//   div_value  in   DIV_W  new divisor (clk cycles per base tick)
//   tick_sel   in   2      0=base 1=x10 2=x100 3=x1000; selects tick_out
//   tick_base  out  1      one-cycle pulse every DIV clk cycles
//   tick_x10   out  1      one-cycle pulse every 10 base ticks
//   tick_x100  out  1      one-cycle pulse every 100 base ticks
//   tick_x1000 out  1      one-cycle pulse every 1000 base ticks
//   tick_out   out  1      copy of tick selected by tick_sel (registered, same cycle as source)
//   div_cur    out  DIV_W  divisor currently in effect
// BEHAVIOUR
//   - Reset (async): div_reg=DEFAULT_DIV, presc=0, dec1=dec2=dec3=0, all tick outputs=0,
//     div_cur=DEFAULT_DIV. Reset takes effect immediately, mid-count included.
//   - Effective divisor: D = (div_reg<2) ? 1 : div_reg. Values 0 and 1 both give a tick
//     every cycle.
//   - All tick outputs are registered and default to 0 on every edge; a tick is never
//     high for two consecutive cycles unless D=1.
//   - Prescaler, per edge with run=1, no clr, no load:
//     - presc==D-1: presc<=0, tick_base<=1, decade chain steps.
//     - Otherwise: presc<=presc+1.
//     - First tick_base is high after exactly D edges with run=1.
//   - Decade chain, updated only on base-tick edges, counters 0..9 wrap:
//     - dec1 steps every base tick. dec1==9 -> dec1<=0, tick_x10<=1, dec2 steps.
//     - dec2==9 at that step -> dec2<=0, tick_x100<=1, dec3 steps.
//     - dec3==9 at that step -> dec3<=0, tick_x1000<=1.
//     - Coincident ticks are asserted on the same edge. Example: the 1000th base tick
//       raises tick_base, tick_x10, tick_x100 and tick_x1000 together.
//   - run=0: presc and decades hold, no tick asserted, divisor load still honoured.
//   - sync_clr=1: presc, dec1..3 <=0, no tick that edge. Independent of run.
//   - div_load=1: div_reg<=div_value, presc, dec1..3 <=0, no tick that edge. New D counts
//     from the next edge. div_load with sync_clr same edge: load and clear both occur.
//     div_load with terminal count same edge: load wins, no tick.
//   - Divisor change without div_load is impossible; div_value is ignored otherwise.
//   - tick_out <= mux(tick_sel) of the next-state tick values, so tick_out is coincident
//     with its source. tick_sel change takes effect at the next tick edge; no glitch pulse.
//   - presc never exceeds D-1 because every divisor change clears it.
//   - Prescaler width is DIV_W. Decade counters are 4 bits each.
// TESTING
//   1 reset, run=1, default div -> tick_base first high at edge 1000, then every 1000
//     cycles; tick_x10 first at edge 10000.
//   2 div_load div_value=4, run=1 -> tick_base at edges 4,8,12,...;
//     tick_x10 at edge 40; tick_x100 at edge 400; tick_x100 coincides with tick_x10
//     and tick_base.
//   3 div_value=0, then div_value=1 -> tick_base high every cycle after load;
//     tick_x10 every 10 cycles.
//   4 D=4: run low for 5 cycles at presc=2 -> no ticks while low; next tick 2 edges
//     after run returns high.
//   5 D=4: sync_clr at presc=3 (terminal) -> no tick that edge; next tick 4 edges later.
//     Async reset mid-count -> outputs 0 immediately, div_cur=1000.
//   6 D=4, sweep tick_sel 0..3 -> tick_out matches tick_base/x10/x100/x1000
//     cycle-for-cycle.

Source files
------------

// File: rtl/timer_timebase_gen.sv
// Decade time-base generator for the PLC timer bank.
// Prescaler divides clk by D; a 3-digit decade chain derives x10/x100/x1000.
module timer_timebase_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [1:0]       tick_sel,
  output logic             tick_base,
  output logic             tick_x10,
  output logic             tick_x100,
  output logic             tick_x1000,
  output logic             tick_out,
  output logic [DIV_W-1:0] div_cur
);

  localparam logic [DIV_W-1:0] LP_DEF = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] LP_TWO = DIV_W'(2);
  localparam logic [3:0]       LP_NINE = 4'd9;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_presc;
  logic [3:0]       r_dec1;
  logic [3:0]       r_dec2;
  logic [3:0]       r_dec3;
  logic             r_tick_base;
  logic             r_tick_x10;
  logic             r_tick_x100;
  logic             r_tick_x1000;
  logic             r_tick_out;

  logic [DIV_W-1:0] w_div_eff;
  logic             w_term;
  logic             w_step;
  logic [DIV_W-1:0] w_presc_nxt;
  logic [3:0]       w_dec1_nxt;
  logic [3:0]       w_dec2_nxt;
  logic [3:0]       w_dec3_nxt;
  logic             w_tb_nxt;
  logic             w_t10_nxt;
  logic             w_t100_nxt;
  logic             w_t1000_nxt;
  logic             w_tout_nxt;

  // Divisors 0 and 1 both mean "tick every cycle".
  assign w_div_eff = (r_div < LP_TWO) ? LP_ONE : r_div;
  assign w_term    = (r_presc == (w_div_eff - LP_ONE));

  always_comb begin
    w_presc_nxt = r_presc;
    w_dec1_nxt  = r_dec1;
    w_dec2_nxt  = r_dec2;
    w_dec3_nxt  = r_dec3;
    w_tb_nxt    = 1'b0;
    w_t10_nxt   = 1'b0;
    w_t100_nxt  = 1'b0;
    w_t1000_nxt = 1'b0;
    w_step      = 1'b0;
    if (div_load || sync_clr) begin
      w_presc_nxt = '0;
      w_dec1_nxt  = '0;
      w_dec2_nxt  = '0;
      w_dec3_nxt  = '0;
    end else if (run) begin
      if (w_term) begin
        w_presc_nxt = '0;
        w_tb_nxt    = 1'b1;
        w_step      = 1'b1;
      end else begin
        w_presc_nxt = r_presc + LP_ONE;
      end
    end
    if (w_step) begin
      if (r_dec1 == LP_NINE) begin
        w_dec1_nxt = '0;
        w_t10_nxt  = 1'b1;
        if (r_dec2 == LP_NINE) begin
          w_dec2_nxt = '0;
          w_t100_nxt = 1'b1;
          if (r_dec3 == LP_NINE) begin
            w_dec3_nxt  = '0;
            w_t1000_nxt = 1'b1;
          end else begin
            w_dec3_nxt = r_dec3 + 4'd1;
          end
        end else begin
          w_dec2_nxt = r_dec2 + 4'd1;
        end
      end else begin
        w_dec1_nxt = r_dec1 + 4'd1;
      end
    end
  end

  // Mux the next-state ticks so tick_out lands on the same edge as its source.
  always_comb begin
    w_tout_nxt = 1'b0;
    unique case (tick_sel)
      2'd0: w_tout_nxt = w_tb_nxt;
      2'd1: w_tout_nxt = w_t10_nxt;
      2'd2: w_tout_nxt = w_t100_nxt;
      2'd3: w_tout_nxt = w_t1000_nxt;
      default: w_tout_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div        <= LP_DEF;
      r_presc      <= '0;
      r_dec1       <= '0;
      r_dec2       <= '0;
      r_dec3       <= '0;
      r_tick_base  <= 1'b0;
      r_tick_x10   <= 1'b0;
      r_tick_x100  <= 1'b0;
      r_tick_x1000 <= 1'b0;
      r_tick_out   <= 1'b0;
    end else begin
      if (div_load) begin
        r_div <= div_value;
      end
      r_presc      <= w_presc_nxt;
      r_dec1       <= w_dec1_nxt;
      r_dec2       <= w_dec2_nxt;
      r_dec3       <= w_dec3_nxt;
      r_tick_base  <= w_tb_nxt;
      r_tick_x10   <= w_t10_nxt;
      r_tick_x100  <= w_t100_nxt;
      r_tick_x1000 <= w_t1000_nxt;
      r_tick_out   <= w_tout_nxt;
    end
  end

  assign tick_base  = r_tick_base;
  assign tick_x10   = r_tick_x10;
  assign tick_x100  = r_tick_x100;
  assign tick_x1000 = r_tick_x1000;
  assign tick_out   = r_tick_out;
  assign div_cur    = r_div;

endmodule
